// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
// Optional watchdog build macro: MULT_SHARE_TIMEOUT_EN.
package mult_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int NBITS_DEF = 8;
   localparam int NREQ_DEF  = 4;

   function automatic int timeout_default(input int nbits);
      return 4 * nbits;
   endfunction

endpackage

// File: rtl/mult_share_ctrl_arb.sv
// Rotating-priority select: first set req at or after rr_ptr, wrapping modulo NREQ.
// Purely combinational; no backpressure of its own.
module rr_arbiter_core #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [IDW-1:0]  winner,
   output logic            any_req
);

   logic found;
   int   idx;

   always_comb begin
      winner  = '0;
      any_req = |req;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            winner = IDW'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one sequential multiplier; req-to-gnt 1 cycle, result 1 cycle after armed ready.
// Response held until rsp_ready; no new grant while busy. Optional watchdog: MULT_SHARE_TIMEOUT_EN.
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NBITS       = NBITS_DEF,
   parameter int NREQ        = NREQ_DEF,
   parameter int IDW         = $clog2(NREQ),
   parameter int TIMEOUT_CYC = timeout_default(NBITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*NBITS-1:0] op_a,
   input  logic [NREQ*NBITS-1:0] op_b,
   output logic [NREQ-1:0]       gnt,
   output logic                  mult_start,
   output logic [NBITS-1:0]      mult_a,
   output logic [NBITS-1:0]      mult_b,
   input  logic                  mult_ready,
   input  logic [2*NBITS-1:0]    mult_result,
   input  logic                  mult_sign,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*NBITS-1:0]    rsp_result,
   output logic                  rsp_sign,
   output logic                  busy
`ifdef MULT_SHARE_TIMEOUT_EN
   ,
   output logic                  rsp_err
`endif
);

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner;
   logic           any_req;
   logic           armed;

`ifdef MULT_SHARE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wd_cnt;
`endif

   rr_arbiter_core #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         armed      <= 1'b0;
         gnt        <= '0;
         mult_start <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_sign   <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
         rsp_err    <= 1'b0;
         wd_cnt     <= '0;
`endif
      end else begin
         gnt        <= '0;
         mult_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  mult_a     <= op_a[int'(winner)*NBITS +: NBITS];
                  mult_b     <= op_b[int'(winner)*NBITS +: NBITS];
                  rsp_id     <= winner;
                  gnt        <= NREQ'(1) << winner;
                  mult_start <= 1'b1;
                  rr_ptr     <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               armed <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // ready only counts after it has been seen low for this operation
               if (armed && mult_ready) begin
                  rsp_result <= mult_result;
                  rsp_sign   <= mult_sign;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end
`ifdef MULT_SHARE_TIMEOUT_EN
               else if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  rsp_result <= '0;
                  rsp_sign   <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end
`endif
               else begin
                  if (!mult_ready) armed <= 1'b1;
`ifdef MULT_SHARE_TIMEOUT_EN
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural sequential multiplier model.
module tb_mult_share_ctrl;

   localparam int NB = 8;
   localparam int NR = 4;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*NB-1:0] op_a, op_b;
   logic [NR-1:0] gnt;
   logic          mult_start;
   logic [NB-1:0] mult_a, mult_b;
   logic          mult_ready;
   logic [2*NB-1:0] mult_result;
   logic          mult_sign;
   logic          rsp_valid, rsp_ready;
   logic [1:0]    rsp_id;
   logic [2*NB-1:0] rsp_result;
   logic          rsp_sign;
   logic          busy;
`ifdef MULT_SHARE_TIMEOUT_EN
   logic          rsp_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_starts = 0;

   // multiplier model
   logic signed [2*NB-1:0] m_prod = '0;
   logic m_ready = 1'b1;
   logic stuck = 1'b0;
   int   m_cnt = 0;
   int   lat = 10;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mult_start) begin
         m_ready <= 1'b0;
         m_cnt   <= lat;
         m_prod  <= $signed(mult_a) * $signed(mult_b);
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end else begin
         m_ready <= !stuck;
      end
   end

   assign mult_ready  = m_ready;
   assign mult_sign   = m_prod[2*NB-1];
   assign mult_result = m_prod[2*NB-1] ? -m_prod : m_prod;

   always @(negedge clk) if (mult_start) n_starts <= n_starts + 1;

   mult_share_ctrl #(.NBITS(NB), .NREQ(NR)) dut (
      .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_ready(mult_ready), .mult_result(mult_result), .mult_sign(mult_sign),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_sign(rsp_sign), .busy(busy)
`ifdef MULT_SHARE_TIMEOUT_EN
      , .rsp_err(rsp_err)
`endif
   );

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (gnt != '0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; op_a = '0; op_b = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({gnt, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, rsp_sign, busy} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got gnt=%b st=%b a=%h b=%h v=%b id=%0d r=%h s=%b busy=%b exp all 0",
                            gnt, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, rsp_sign, busy);
      end
`ifdef MULT_SHARE_TIMEOUT_EN
      n_tests++;
      if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", rsp_err); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      op_a[7:0] = 8'hFD; op_b[7:0] = 8'hFE; rsp_ready = 1'b0;
      req = 4'b0001;
      @(negedge clk);
      n_tests++;
      if (gnt !== 4'b0001 || mult_start !== 1'b1) begin
         n_fail++; $display("FAIL single_gnt got gnt=%b start=%b exp 0001/1", gnt, mult_start);
      end
      n_tests++;
      if (mult_a !== 8'hFD || mult_b !== 8'hFE) begin
         n_fail++; $display("FAIL single_operands got a=%h b=%h exp fd/fe", mult_a, mult_b);
      end
      req = '0;
      @(negedge clk);
      n_tests++;
      if (gnt !== '0 || mult_start !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_pulse got gnt=%b start=%b busy=%b exp 0/0/1", gnt, mult_start, busy);
      end
      wait_rsp(ok);
      n_tests++;
      if (!ok || rsp_id !== 2'd0 || rsp_result !== 16'd6 || rsp_sign !== 1'b0) begin
         n_fail++; $display("FAIL single_rsp got ok=%b id=%0d r=%0d s=%b exp 1/0/6/0", ok, rsp_id, rsp_result, rsp_sign);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_handshake got v=%b busy=%b exp 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int s0;
      int eid;
      logic [15:0] exp_res [4];
      exp_res = '{16'd6, 16'd9, 16'd12, 16'd15};
      do_reset();
      for (int i = 0; i < NR; i++) begin
         op_a[i*NB +: NB] = NB'(i + 2);
         op_b[i*NB +: NB] = 8'hFD;
      end
      rsp_ready = 1'b1;
      s0 = n_starts;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         eid = k % NR;
         wait_gnt(ok);
         n_tests++;
         if (!ok || gnt !== (4'b0001 << eid) || mult_start !== 1'b1) begin
            n_fail++; $display("FAIL rr_gnt%0d got ok=%b gnt=%b st=%b exp gnt=%b", k, ok, gnt, mult_start, 4'b0001 << eid);
         end
         if (k == 4) req = '0;
         wait_rsp(ok);
         n_tests++;
         if (!ok || rsp_id !== 2'(eid) || rsp_result !== exp_res[eid] || rsp_sign !== 1'b1) begin
            n_fail++; $display("FAIL rr_rsp%0d got ok=%b id=%0d r=%0d s=%b exp id=%0d r=%0d s=1",
                               k, ok, rsp_id, rsp_result, rsp_sign, eid, exp_res[eid]);
         end
      end
      @(negedge clk);
      n_tests++;
      if (n_starts - s0 != 5 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rr_starts got starts=%0d busy=%b exp 5/0", n_starts - s0, busy);
      end
   endtask

   task automatic test_wrap_fairness();
      bit ok;
      do_reset();
      rsp_ready = 1'b1;
      req = 4'b0100;
      wait_gnt(ok);
      req = 4'b1001;
      wait_rsp(ok);
      wait_gnt(ok);
      n_tests++;
      if (!ok || gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got ok=%b gnt=%b exp 1000", ok, gnt); end
      req = 4'b0001;
      wait_rsp(ok);
      n_tests++;
      if (!ok || rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3 got ok=%b id=%0d exp 3", ok, rsp_id); end
      wait_gnt(ok);
      n_tests++;
      if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_second got ok=%b gnt=%b exp 0001", ok, gnt); end
      req = '0;
      wait_rsp(ok);
      n_tests++;
      if (!ok || rsp_id !== 2'd0) begin n_fail++; $display("FAIL wrap_id0 got ok=%b id=%0d exp 0", ok, rsp_id); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      op_a[7:0] = 8'd5; op_b[7:0] = 8'd7;
      op_a[15:8] = 8'd1; op_b[15:8] = 8'd1;
      rsp_ready = 1'b0;
      req = 4'b0001;
      wait_gnt(ok);
      req = 4'b0010;
      wait_rsp(ok);
      for (int c = 0; c < 5; c++) begin
         n_tests++;
         if (!ok || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'd35 || rsp_sign !== 1'b0 || gnt !== '0) begin
            n_fail++; $display("FAIL bp_hold%0d got v=%b id=%0d r=%0d s=%b gnt=%b exp 1/0/35/0/0000",
                               c, rsp_valid, rsp_id, rsp_result, rsp_sign, gnt);
         end
         if (c < 4) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || gnt !== '0) begin
         n_fail++; $display("FAIL bp_release got v=%b gnt=%b exp 0/0000", rsp_valid, gnt);
      end
      @(negedge clk);
      n_tests++;
      if (gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_next_gnt got %b exp 0010", gnt); end
      req = '0;
      wait_rsp(ok);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      bit saw;
      rsp_ready = 1'b1;
      req = 4'b0010;
      wait_gnt(ok);
      req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({gnt, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, rsp_sign, busy} !== '0) begin
         n_fail++; $display("FAIL midwait_reset got gnt=%b st=%b a=%h b=%h v=%b id=%0d r=%h busy=%b exp all 0",
                            gnt, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, busy);
      end
      rst = 1'b0;
      saw = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      n_tests++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL midwait_no_rsp got saw_valid=%b exp 0", saw); end
      req = 4'b1111;
      wait_gnt(ok);
      n_tests++;
      if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL midwait_ptr got ok=%b gnt=%b exp 0001", ok, gnt); end
      req = '0;
      wait_rsp(ok);
      @(negedge clk);
   endtask

`ifdef MULT_SHARE_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int n;
      stuck = 1'b1;
      rsp_ready = 1'b0;
      req = 4'b0001;
      wait_gnt(ok);
      req = '0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (rsp_valid) break;
      end
      n_tests++;
      if (n != TO + 1 || rsp_err !== 1'b1 || rsp_result !== '0 || rsp_sign !== 1'b0) begin
         n_fail++; $display("FAIL timeout got cycles=%0d err=%b r=%0d s=%b exp %0d/1/0/0",
                            n, rsp_err, rsp_result, rsp_sign, TO + 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_clear got err=%b v=%b exp 0/0", rsp_err, rsp_valid);
      end
      stuck = 1'b0;
      repeat (3) @(negedge clk);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_fairness();
      test_backpressure();
      test_reset_mid_wait();
`ifdef MULT_SHARE_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Round-robin controller that shares one sequential signed shift-add multiplier among NREQ requesters. It sits between the requester ports and the multiplier top (start/ready/result interface). It arbitrates, captures operands, pulses start, and waits for completion. It then returns result, sign and requester ID over a valid/ready response channel. Only one multiplication is in flight at any time.

Parameters:
NBITS, 8, operand width (two's complement)
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), requester ID width
TIMEOUT_CYC, 4*NBITS, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NREQ  request per requester, level, held until gnt
op_a  in  NREQ*NBITS  multiplier operand per requester, slice i = requester i
op_b  in  NREQ*NBITS  multiplicand operand per requester
gnt  out  NREQ  one-hot, one-cycle grant pulse (operands captured)
mult_start  out  1  one-cycle start pulse to the multiplier
mult_a  out  NBITS  registered multiplier operand
mult_b  out  NBITS  registered multiplicand operand
mult_ready  in  1  multiplier ready level
mult_result  in  2*NBITS  multiplier magnitude result
mult_sign  in  1  multiplier result sign
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester index of the response
rsp_result  out  2*NBITS  captured magnitude
rsp_sign  out  1  captured sign
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, clk edge with rst=1), which wins over every other event:
  - All outputs 0; state IDLE; round-robin pointer rr_ptr=0; ready-armed flag cleared.
  - Reset in any state aborts the operation. No response is issued for the aborted operation, and the multiplier is not stopped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If |req, the winner is the first set req index at or after rr_ptr, wrapping modulo NREQ.
  - At the edge: latch op_a/op_b slices into mult_a/mult_b, latch the winner ID, set gnt[winner]=1 and mult_start=1, and set rr_ptr=(winner+1) mod NREQ. Go to ISSUE.
  - If no req is set, stay in IDLE. The pointer is unchanged.
- ISSUE (exactly 1 cycle):
  - gnt and mult_start are high in this cycle only.
  - Clear the ready-armed flag. Go to WAIT.
- WAIT:
  - mult_start=0. mult_a/mult_b are held stable.
  - Set the armed flag on the first cycle mult_ready=0.
  - When armed and mult_ready=1: capture mult_result/mult_sign into rsp_result/rsp_sign, set rsp_valid=1, and go to RESP. This makes stale ready from the previous operation harmless.
  - A multiplier that never deasserts ready hangs here unless the optional feature is compiled in.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_sign are held stable until rsp_valid and rsp_ready are both high at an edge.
  - On that edge: rsp_valid=0, go to IDLE. A new grant cannot occur before the following cycle.
- Latency:
  - req-to-gnt: 1 cycle.
  - Completion-to-rsp_valid: 1 cycle after ready is seen high while armed.
  - Minimum back-to-back spacing: 4 cycles plus the multiplier time.
- Arbitration rules:
  - Requests arriving while busy are not lost. They are served in IDLE in rotation order.
  - Requester i must hold req[i] and its operands until it sees gnt[i]. Deasserting before gnt withdraws the request.
- Output rules: gnt is always one-hot or zero, and mult_start coincides with the gnt pulse.

Optional Feature:
Macro MULT_SHARE_TIMEOUT_EN.
- With it:
  - Add a cycle counter, cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC without completion, go to RESP with rsp_result=0, rsp_sign=0, and extra output port rsp_err=1 (rsp_err reset 0).
  - rsp_err is held with the response and cleared on handshake.
- Without it: no counter and no rsp_err port. WAIT lasts until completion.

Decomposition:
- Package mult_share_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - the default NBITS/NREQ constants;
  - the function for the default TIMEOUT_CYC.
- One sub-module, rr_arbiter_core: combinational rotating priority select from req and rr_ptr, producing winner index and any_req. It is reused by other shared-resource controllers.

Test Plan:
1. Single request: req=0001, op_a=-3, op_b=-2, model multiplier ready after 10 cycles with result 6, sign 0 -> gnt=0001 one cycle after req, mult_start pulse in the same cycle, then rsp_valid with id=0, result=6, sign=0.
2. Simultaneous requests: req=1111 held with rsp_ready=1 -> grant order 0,1,2,3,0. Each rsp_id matches its grant, and only one mult_start per operation.
3. Fairness after wrap: requester 3 and requester 0 pending with rr_ptr=3 -> requester 3 served first, then 0.
4. Backpressure: rsp_ready=0 for 5 cycles with op 5*7 -> rsp_valid, id and result=35 stable for all 5 cycles. No new gnt until the handshake completes.
5. Reset mid-WAIT: rst for 1 cycle during WAIT -> next cycle all outputs 0, state IDLE, rr_ptr=0, and no response for the aborted operation.
6. With MULT_SHARE_TIMEOUT_EN: multiplier ready stuck at 0 -> exactly TIMEOUT_CYC cycles in WAIT, then rsp_valid=1, rsp_err=1, rsp_result=0.
